pc_fetch_unit: RTL and testbench

//  Architectural PC register and instruction-fetch sequencer; consumer side of the next-PC interface.

---
 rtl/pc_fetch_unit.sv | 134 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Architectural PC register and instruction-fetch sequencer. The block holds
//   curPC, fetches the word at curPC from instruction memory with a req/ack
//   handshake, and buffers the word for decode behind a valid/ready handshake.
//   curPC loads nextPC only when decode consumes the buffered word while
//   PCWre=1. If a request goes unacknowledged for MAX_WAIT cycles, the block
//   parks in a sticky error state that only reset clears.
//
// Parameters
//   RESET_PC     value curPC takes on reset
//   MAX_WAIT     cycles a request may stay unacknowledged before a fault (>=1)
//
// Ports
//   CLK          in   1   clock, rising edge
//   Reset        in   1   asynchronous, active-low reset
//   nextPC       in   32  next PC from the next-PC logic
//   PCWre        in   1   PC write enable (0 = stall)
//   curPC        out  32  current PC
//   imem_req     out  1   instruction memory request
//   imem_addr    out  32  request address (always curPC)
//   imem_ack     in   1   memory returns data this cycle
//   imem_rdata   in   32  instruction word, valid with imem_ack
//   instr        out  32  buffered instruction for decode
//   instr_valid  out  1   instr holds an unconsumed word
//   instr_ready  in   1   decode accepts instr this cycle
//   fetch_err    out  1   sticky fetch fault
//
// Configuration macro
//   PC_ALIGN_CHECK_EN  when defined, a misaligned nextPC at consume is a fault
//                      (curPC is held and the block enters ERR). When
//                      undefined, nextPC is silently word-aligned on load.
//
// State table
//   IDLE | held in reset; leaves on the first edge after release
//   REQ  | request outstanding at curPC, wait counter running
//   BUF  | word buffered for decode, waiting for consume
//   ERR  | sticky fault, no requests until reset
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] nextPC,
  input  logic        PCWre,
  output logic [31:0] curPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUF  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int            CW        = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          consume;

  assign consume = (state == BUF) && instr_valid && instr_ready && PCWre;

  // Request and fault flags are pure decodes of the state register.
  assign imem_req  = (state == REQ);
  assign fetch_err = (state == ERR);
  // Same register as curPC, so the request after a load carries the new PC.
  assign imem_addr = curPC;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      curPC       <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          wait_cnt <= '0;
        end
        REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= BUF;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        BUF: begin
          // instr_ready with PCWre=0 is a stall: nothing changes here.
          if (consume) begin
            instr_valid <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            if (nextPC[1:0] != 2'b00) begin
              state <= ERR;
            end else begin
              curPC    <= nextPC;
              wait_cnt <= '0;
              state    <= REQ;
            end
`else
            curPC    <= nextPC & 32'hFFFF_FFFC;
            wait_cnt <= '0;
            state    <= REQ;
`endif
          end
        end
        ERR: begin
          instr_valid <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam int MAX_WAIT = 16;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] nextPC = '0;
  logic        PCWre = 1'b0;
  logic [31:0] curPC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        fetch_err;

  always #5 CLK = ~CLK;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .Reset(Reset), .nextPC(nextPC), .PCWre(PCWre), .curPC(curPC),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fetch_err(fetch_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: tracks whether fetching has begun, whether a word is
  // held for decode, how long the current request has waited, and the fault.
  bit          m_started, m_have, m_err;
  int          m_wait;
  logic [31:0] m_pc, m_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_started = 0; m_have = 0; m_err = 0; m_wait = 0;
    m_pc = 32'h0; m_instr = 32'h0;
  endtask

  task automatic model_edge();
    if (!m_started) begin
      m_started = 1; m_wait = 0;
    end else if (m_err) begin
    end else if (!m_have) begin
      if (imem_ack) begin
        m_have = 1; m_instr = imem_rdata;
      end else begin
        m_wait = m_wait + 1;
        if (m_wait >= MAX_WAIT) m_err = 1;
      end
    end else if (instr_ready && PCWre) begin
      m_have = 0;
`ifdef PC_ALIGN_CHECK_EN
      if (nextPC % 4 != 0) m_err = 1;
      else begin m_pc = nextPC; m_wait = 0; end
`else
      m_pc = nextPC - (nextPC % 4);
      m_wait = 0;
`endif
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " curPC"},       curPC,       m_pc);
    chk({tag, " imem_addr"},   imem_addr,   m_pc);
    chk({tag, " imem_req"},    {31'b0, imem_req},    {31'b0, m_started && !m_have && !m_err});
    chk({tag, " instr_valid"}, {31'b0, instr_valid}, {31'b0, m_have});
    chk({tag, " instr"},       instr,       m_instr);
    chk({tag, " fetch_err"},   {31'b0, fetch_err},   {31'b0, m_err});
  endtask

  task automatic drive(input logic a, input logic [31:0] rd, input logic rdy,
                       input logic we, input logic [31:0] np);
    imem_ack = a; imem_rdata = rd; instr_ready = rdy; PCWre = we; nextPC = np;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b0;
    model_reset();
    #1;
    check_model("reset");
    @(posedge CLK);
    #1;
    Reset = 1'b1;
  endtask

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        we;
    logic [31:0] np;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_err;
  } vec_t;

  vec_t tbl[12];

  initial begin
    //          ack rdata          rdy we  nextPC        pc            req valid instr         err
    tbl[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 32'h2001_0005, 1'b1, 1'b1, 32'h4, 32'h0, 1'b0, 1'b1, 32'h2001_0005, 1'b0};
    tbl[2]  = '{1'b1, 32'h2001_0005, 1'b1, 1'b1, 32'h4, 32'h4, 1'b1, 1'b0, 32'h2001_0005, 1'b0};
    tbl[3]  = '{1'b1, 32'hAABB_CCDD, 1'b1, 1'b0, 32'h8, 32'h4, 1'b0, 1'b1, 32'hAABB_CCDD, 1'b0};
    tbl[4]  = '{1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h8, 32'h4, 1'b0, 1'b1, 32'hAABB_CCDD, 1'b0};
    tbl[5]  = '{1'b0, 32'h1111_1111, 1'b1, 1'b0, 32'h8, 32'h4, 1'b0, 1'b1, 32'hAABB_CCDD, 1'b0};
    tbl[6]  = '{1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'h8, 32'h4, 1'b0, 1'b1, 32'hAABB_CCDD, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h8, 32'h8, 1'b1, 1'b0, 32'hAABB_CCDD, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h8, 32'h8, 1'b1, 1'b0, 32'hAABB_CCDD, 1'b0};
    tbl[9]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hC, 32'h8, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    tbl[10] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hC, 32'h8, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hC, 32'hC, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0};

    // Outputs must read zero while reset is held.
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h10);
    #1;
    chk("in-reset imem_req",    {31'b0, imem_req},    32'h0);
    chk("in-reset instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("in-reset curPC",       curPC,                32'h0);
    apply_reset();

    // Directed vector table: startup, fetch/consume, stall, decode back-pressure.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ack, tbl[i].rdata, tbl[i].rdy, tbl[i].we, tbl[i].np);
      tick();
      chk($sformatf("vec%0d curPC", i),       curPC,                  tbl[i].e_pc);
      chk($sformatf("vec%0d imem_addr", i),   imem_addr,              tbl[i].e_pc);
      chk($sformatf("vec%0d imem_req", i),    {31'b0, imem_req},      {31'b0, tbl[i].e_req});
      chk($sformatf("vec%0d instr_valid", i), {31'b0, instr_valid},   {31'b0, tbl[i].e_valid});
      chk($sformatf("vec%0d instr", i),       instr,                  tbl[i].e_instr);
      chk($sformatf("vec%0d fetch_err", i),   {31'b0, fetch_err},     {31'b0, tbl[i].e_err});
    end

    // Request timeout: 15 unacked cycles are tolerated, the 16th faults.
    apply_reset();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h4);
    tick();
    for (int k = 1; k < MAX_WAIT; k++) tick();
    chk("timeout-1 imem_req",  {31'b0, imem_req},  32'h1);
    chk("timeout-1 fetch_err", {31'b0, fetch_err}, 32'h0);
    tick();
    chk("timeout fetch_err", {31'b0, fetch_err}, 32'h1);
    chk("timeout imem_req",  {31'b0, imem_req},  32'h0);
    drive(1'b1, 32'hFFFF_0000, 1'b1, 1'b1, 32'h4);
    for (int k = 0; k < 3; k++) tick();
    chk("late-ack fetch_err",   {31'b0, fetch_err},   32'h1);
    chk("late-ack instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("late-ack instr",       instr,                32'h0);
    chk("late-ack curPC",       curPC,                32'h0);
    apply_reset();
    chk("post-reset fetch_err", {31'b0, fetch_err}, 32'h0);

    // Misaligned nextPC at consume.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h0000_0123, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0013);
    tick();
`ifdef PC_ALIGN_CHECK_EN
    chk("misalign fetch_err",   {31'b0, fetch_err},   32'h1);
    chk("misalign curPC",       curPC,                32'h0);
    chk("misalign instr_valid", {31'b0, instr_valid}, 32'h0);
`else
    chk("misalign curPC",     curPC,              32'h0040_0010);
    chk("misalign imem_addr", imem_addr,          32'h0040_0010);
    chk("misalign fetch_err", {31'b0, fetch_err}, 32'h0);
`endif
    check_model("misalign");

    // Asynchronous reset while a word sits in the buffer.
    apply_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h4);
    tick();
    drive(1'b1, 32'h5555_AAAA, 1'b0, 1'b0, 32'h4);
    tick();
    chk("buf instr_valid", {31'b0, instr_valid}, 32'h1);
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    chk("async-rst instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("async-rst curPC",       curPC,                32'h0);
    chk("async-rst instr",       instr,                32'h0);
    chk("async-rst imem_req",    {31'b0, imem_req},    32'h0);
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h4);
    tick();
    chk("restart imem_req",  {31'b0, imem_req}, 32'h1);
    chk("restart imem_addr", imem_addr,         32'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      if (m_err && $urandom_range(0, 3) == 0) apply_reset();
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0,
            ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
